io_uart_tx: RTL
===============

Name: io_uart_tx

Overview:
- Memory-mapped serial transmitter on the computer's I/O bus (io_addr/io_data/io_oe/io_we); consumes the bytes the CPU writes out.
- Buffers CPU writes in a small FIFO and serialises them as 8N1 frames on a tx pin.
- Exposes a status register so programs can poll before writing.
- The top level owns the tri-state io_data net; this block uses split in/out data with a drive enable.

Parameters:
- BASE_ADDR, 4'hC, io_addr of DATA register; STATUS register is BASE_ADDR+1 (mod 16).
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..8.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- io_addr  in  4  I/O address from the CPU.
- io_data_in  in  8  write data, valid when io_we=1.
- io_we  in  1  write strobe; each high cycle is one write.
- io_oe  in  1  read strobe.
- io_data_out  out  8  read data; 8'h00 when not selected.
- io_data_drive  out  1  io_oe && address hit; top level enables the tri driver with it.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  high while state != IDLE.

Behaviour:
- Reset: FIFO emptied, overflow=0, state=IDLE, tx=1, tx_busy=0, io_data_out=0, io_data_drive=0. Reset mid-frame aborts the frame; tx is high from the next edge.
- DATA write (io_we && io_addr==BASE_ADDR):
  - FIFO not full: push io_data_in.
  - FIFO full: byte dropped; overflow set sticky. Full is evaluated before any same-cycle pop, so a push coinciding with a pop on a full FIFO is still dropped.
- STATUS write (io_we && io_addr==BASE_ADDR+1): io_data_in[3]=1 clears overflow; other bits ignored. An overflow event in the same cycle wins, so overflow stays 1.
- Reads are combinational with zero latency; the CPU samples in the same cycle.
  - DATA read: 8'h00.
  - STATUS read: [0] empty, [1] full, [2] tx_busy, [3] overflow, [7:4] FIFO count (0..FIFO_DEPTH).
  - Reads have no side effects.
- io_we and io_oe both high: the write executes; the read returns pre-write state.
- TX FSM:
  - IDLE: if FIFO non-empty, pop into shift register, baud counter=0, go to START. tx_busy rises on the following edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back bytes: at least one IDLE cycle between frames. Frame period is 10*CLKS_PER_BIT+1 cycles.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT).
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- tx is registered (glitch-free).

Decomposition:
- Package io_map_pkg holds:
  - the I/O address constants (UART DATA/STATUS offsets);
  - STATUS bit positions (ST_EMPTY=0, ST_FULL=1, ST_BUSY=2, ST_OVF=3, ST_CNT_LSB=4);
  - the tx state encoding (IDLE, START, DATA, STOP).
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count, single clock, synchronous reset. It is reused later by an RX block.

Test Plan:
- Use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset then STATUS read: io_data_out=8'h01 (empty), io_data_drive=1, tx=1, tx_busy=0.
- Write 8'hA5 to DATA: tx goes low one cycle after the push, for 4 cycles. Bits 1,0,1,0,0,1,0,1 follow, 4 cycles each. Stop is high 4 cycles. tx_busy falls 41 cycles after the pop.
- Write 5 bytes in consecutive cycles (01..05) while idle: the first pops immediately and 4 fit, so none is dropped. Write a 6th byte while 4 are queued: it is dropped. STATUS reads 8'h4E (count 4, ovf, busy, full). Serial output is 01,02,03,04,05; the 6th byte never appears.
- STATUS write 8'h08: overflow clears; next STATUS read shows bit3=0.
- Assert reset mid-DATA bit of 8'h3C: tx=1 the next cycle; STATUS reads 8'h01; no further start bit without a new write.
- Read with io_oe=1 and io_addr not matching either register: io_data_drive=0, io_data_out=8'h00, no state change.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: I/O map constants, STATUS bit positions and UART tx state encoding.
package io_map_pkg;
  localparam logic [3:0] UART_BASE = 4'hC;
  localparam logic [3:0] UART_DATA_OFS = 4'd0;
  localparam logic [3:0] UART_STATUS_OFS = 4'd1;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT_LSB = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 serial transmitter with write FIFO and STATUS register.
module io_uart_tx import io_map_pkg::*; #(
  parameter logic [3:0] BASE_ADDR = UART_BASE,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic [7:0] io_data_in,
  input  logic       io_we,
  input  logic       io_oe,
  output logic [7:0] io_data_out,
  output logic       io_data_drive,
  output logic       tx,
  output logic       tx_busy
);
  localparam logic [3:0] DATA_ADDR = BASE_ADDR + UART_DATA_OFS;
  localparam logic [3:0] STAT_ADDR = BASE_ADDR + UART_STATUS_OFS;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shift, dout, status;
  logic [CW-1:0] count;
  logic hit_data, hit_stat, wr_data, full, empty, pop, overflow, baud_last;
  assign hit_data = io_addr == DATA_ADDR;
  assign hit_stat = io_addr == STAT_ADDR;
  assign wr_data = io_we && hit_data;
  assign pop = state == IDLE && !empty;
  assign baud_last = baud == BW'(CLKS_PER_BIT - 1);
  assign io_data_drive = io_oe && (hit_data || hit_stat);
  assign io_data_out = io_oe && hit_stat ? status : 8'h00;
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_BUSY] = tx_busy;
    status[ST_OVF] = overflow;
    status[ST_CNT_LSB +: 4] = 4'(count);
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_data), .pop(pop), .din(io_data_in),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  // A dropped byte in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk)
    overflow <= reset ? 1'b0 : wr_data && full ? 1'b1 :
                io_we && hit_stat && io_data_in[ST_OVF] ? 1'b0 : overflow;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      tx_busy <= 1'b0;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      baud <= state == IDLE || baud_last ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (pop) begin
          shift <= dout;
          state <= START;
          tx <= 1'b0;
          tx_busy <= 1'b1;
        end
        START: if (baud_last) begin
          state <= DATA;
          bit_idx <= '0;
          tx <= shift[0];
        end
        DATA: if (baud_last) begin
          if (bit_idx == 3'd7) begin
            state <= STOP;
            tx <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shift <= shift >> 1;
            tx <= shift[1];
          end
        end
        default: if (baud_last) begin
          state <= IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
